btb_ctrl: RTL and testbench
===========================

# btb_ctrl

Controller for the 1024-entry branch-target storage array of the pipelined core's branch predictor. It performs the fetch-stage lookup: index, tag compare and valid qualification. It also sequences execute-stage updates (insert and evict) into the array's single write port. Because the array has no reset, the block runs a clearing sweep after reset and on a pipeline flush request, and holds back updates that arrive during the sweep.

## Interface
Parameters:
- IDX_W, 10, array index width (entries = 2^IDX_W)
- TAG_W, 20, tag width = 30 − IDX_W

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fetch_vld  in  1  fetch-stage PC is valid this cycle
- fetch_pc  in  32  fetch-stage PC
- pred_taken  out  1  BTB hit: predict taken
- pred_pc  out  32  predicted target, {target[31:2],2'b00}
- upd_vld  in  1  execute-stage branch resolved
- upd_pc  in  32  PC of the resolved branch
- upd_target  in  32  resolved target
- upd_taken  in  1  branch was taken
- upd_was_hit  in  1  branch had been predicted by the BTB
- flush_req  in  1  request a full BTB invalidate
- btb_ready  out  1  block is in RUN state
- arr_r_addr  out  IDX_W  array read index
- arr_tag_rd  in  TAG_W  array read tag
- arr_vld_rd  in  1  array read valid
- arr_tgt_rd  in  30  array read target[31:2]
- arr_w_en  out  1  array write enable
- arr_w_addr  out  IDX_W  array write index
- arr_tag_wr  out  TAG_W  array write tag
- arr_vld_wr  out  1  array write valid bit
- arr_tgt_wr  out  30  array write target[31:2]

## Operation
- Address split: index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
- Lookup path is combinational:
  - arr_r_addr = index(fetch_pc).
  - pred_taken = fetch_vld & btb_ready & arr_vld_rd & (arr_tag_rd == tag(fetch_pc)).
  - pred_pc = {arr_tgt_rd,2'b00} when pred_taken, else 0.
- FSM states: INIT, RUN, FLUSH. INIT and FLUSH behave identically; the two encodings exist for debug only.
  - rst → INIT with sweep_cnt = 0.
  - INIT/FLUSH: each cycle writes arr_w_en=1, arr_w_addr=sweep_cnt, arr_vld_wr=0, tag=0, tgt=0, then increments sweep_cnt. Write at sweep_cnt = 2^IDX_W−1 → RUN, sweep_cnt wraps to 0.
  - RUN: on flush_req → FLUSH with sweep_cnt = 0.
  - flush_req in INIT/FLUSH restarts the sweep at index 0.
- Update translation, applied to any accepted update U:
  - U.taken → write {tag(U.pc), vld=1, U.target[31:2]} at index(U.pc).
  - !U.taken & U.was_hit → write vld=0, tag/tgt = 0 (evict).
  - !U.taken & !U.was_hit → no write.
- Pending register: one entry, pend_vld plus the stored update.
  - In INIT/FLUSH, a writing upd_vld is captured into pending. A newer update overwrites an older one; the latest wins.
  - In RUN:
    - If pend_vld, the pending entry is written this cycle, and a concurrent writing upd_vld is captured into pending.
    - Otherwise the upd_vld write goes straight to the array.
- flush_req clears pend_vld and discards any same-cycle upd_vld.

## Timing
- Lookup latency is 0 cycles (same-cycle combinational).
- Update write lands at the clk edge of acceptance in RUN with no pending entry. With a pending entry it lands one cycle later.
- Same-index lookup and write in one cycle: lookup returns the pre-write contents.
- Sweep takes exactly 2^IDX_W cycles (1024 by default). btb_ready rises on the first RUN cycle.
- Values while rst=1:
  - Outputs: arr_w_en=0, btb_ready=0, pred_taken=0.
  - Registers: pend_vld=0, sweep_cnt=0, state=INIT.
- Reset mid-sweep or mid-update: any in-flight write is dropped and the sweep restarts from 0 after rst deasserts.

## Configuration
- BTB_STATS_EN:
  - Defined: adds output ports stat_lookups[31:0] and stat_hits[31:0], reset to 0.
  - stat_lookups increments on fetch_vld & btb_ready. stat_hits increments on pred_taken.
  - Both counters saturate at 32'hFFFF_FFFF and clear on flush_req.
  - Undefined: the ports and counters are absent; no other behaviour changes.

## Test plan
- Reset, then count cycles → arr_w_en=1 for exactly 1024 cycles with addr 0..1023 and vld_wr=0; btb_ready=1 at cycle 1024.
- In RUN: upd_pc=0x0000_1040, target=0x0000_2000, taken=1. Next cycle fetch_pc=0x0000_1040 → pred_taken=1, pred_pc=0x0000_2000. Then fetch_pc=0x0000_2040 (same index, different tag) → pred_taken=0.
- Not-taken update with was_hit=1 for 0x1040 → entry evicted, next lookup misses. Repeat with was_hit=0 → arr_w_en stays 0.
- Two updates (0x100→0x500, then 0x100→0x600) issued during the sweep → only the 0x600 entry is written, on the first RUN cycle. A same-cycle new update is written the following cycle.
- flush_req in RUN, asserted together with upd_vld → update discarded, 1024-cycle sweep, prior entries miss afterward. flush_req at sweep index 500 → sweep restarts at 0.
- With BTB_STATS_EN: 10 lookups, 4 hits → stat_lookups=10, stat_hits=4. Then flush_req → both counters read 0.

Source files
------------

// File: rtl/btb_ctrl.sv
// btb_ctrl: branch-target buffer controller. Does the fetch lookup (index, tag, valid)
//   and funnels execute-stage updates plus a clearing sweep into one array write port.
// Latency: lookup 0 cycles. An update writes on its accept edge, or one cycle later if
//   an older update is still pending.
// Backpressure: none. Updates seen during a sweep park in a one-deep pending slot; the
//   newest one wins.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   fetch_vld/fetch_pc          fetch-stage lookup request
//   pred_taken/pred_pc          hit and predicted target (0 on a miss)
//   upd_*                       resolved-branch update from execute
//   flush_req                   invalidate the whole BTB (restarts the sweep)
//   btb_ready                   high while in RUN
//   arr_r_addr, arr_*_rd        array read port (combinational read data)
//   arr_w_en, arr_w_addr, arr_*_wr   array write port
//   stat_lookups, stat_hits     only present when BTB_STATS_EN is defined
//
// Optional feature macro: BTB_STATS_EN (lookup/hit counters).

module btb_ctrl #(
  parameter int IDX_W = 10,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_vld,
  input  logic [31:0]       fetch_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_pc,
  input  logic              upd_vld,
  input  logic [31:0]       upd_pc,
  input  logic [31:0]       upd_target,
  input  logic              upd_taken,
  input  logic              upd_was_hit,
  input  logic              flush_req,
  output logic              btb_ready,
  output logic [IDX_W-1:0]  arr_r_addr,
  input  logic [TAG_W-1:0]  arr_tag_rd,
  input  logic              arr_vld_rd,
  input  logic [29:0]       arr_tgt_rd,
  output logic              arr_w_en,
  output logic [IDX_W-1:0]  arr_w_addr,
  output logic [TAG_W-1:0]  arr_tag_wr,
  output logic              arr_vld_wr,
  output logic [29:0]       arr_tgt_wr
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_hits
`endif
);

  // INIT and FLUSH act the same. They are kept apart only so that a debugger can
  // tell a power-on sweep from a flush sweep.
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             vld;
    logic [29:0]      tgt;
  } wr_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic             pend_vld_q, pend_vld_d;
  wr_t              pend_q, pend_d;

  logic             wr_en;
  wr_t              wr;
  logic             upd_wr;
  wr_t              upd_ent;
  logic             run;
  logic             unused_bits;

  // The two low PC/target bits are always zero for aligned instructions.
  assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign run = (state_q == ST_RUN) & ~rst;

  // ------------------------------------------------------------------
  // Lookup path (combinational)
  // ------------------------------------------------------------------
  assign arr_r_addr = fetch_pc[IDX_W+1:2];
  assign btb_ready  = run;
  assign pred_taken = fetch_vld & run & arr_vld_rd &
                      (arr_tag_rd == fetch_pc[31:IDX_W+2]);
  assign pred_pc    = pred_taken ? {arr_tgt_rd, 2'b00} : 32'd0;

  // ------------------------------------------------------------------
  // Update translation. A taken branch installs its entry. A not-taken branch
  // that the BTB had predicted evicts its entry. Anything else writes nothing.
  // ------------------------------------------------------------------
  assign upd_wr = upd_vld & (upd_taken | upd_was_hit);

  always_comb begin
    upd_ent     = '0;
    upd_ent.idx = upd_pc[IDX_W+1:2];
    if (upd_taken) begin
      upd_ent.tag = upd_pc[31:IDX_W+2];
      upd_ent.vld = 1'b1;
      upd_ent.tgt = upd_target[31:2];
    end
  end

  // ------------------------------------------------------------------
  // Next-state and write-port selection
  // ------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_d      = pend_q;
    wr_en       = 1'b0;
    wr          = '0;

    case (state_q)
      ST_INIT, ST_FLUSH: begin
        // Clear one entry every cycle. Updates are parked, not written.
        wr_en  = 1'b1;
        wr.idx = sweep_cnt_q;
        if (flush_req) begin
          sweep_cnt_d = '0;
          pend_vld_d  = 1'b0;
        end else begin
          if (upd_wr) begin
            pend_vld_d = 1'b1;
            pend_d     = upd_ent;
          end
          sweep_cnt_d = sweep_cnt_q + 1'b1;   // wraps to 0 after the last entry
          if (sweep_cnt_q == {IDX_W{1'b1}}) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (flush_req) begin
          // A flush drops both the parked update and this cycle's update.
          state_d     = ST_FLUSH;
          sweep_cnt_d = '0;
          pend_vld_d  = 1'b0;
        end else if (pend_vld_q) begin
          // The parked update takes the port. A new update takes its slot.
          wr_en      = 1'b1;
          wr         = pend_q;
          pend_vld_d = upd_wr;
          if (upd_wr) begin
            pend_d = upd_ent;
          end
        end else if (upd_wr) begin
          wr_en = 1'b1;
          wr    = upd_ent;
        end
      end

      default: begin
        state_d     = ST_INIT;
        sweep_cnt_d = '0;
        pend_vld_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      sweep_cnt_q <= '0;
      pend_vld_q  <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_q      <= pend_d;
    end
  end

  // The write port stays quiet while reset is held, so any in-flight write is dropped.
  assign arr_w_en   = wr_en & ~rst;
  assign arr_w_addr = wr.idx;
  assign arr_tag_wr = wr.tag;
  assign arr_vld_wr = wr.vld;
  assign arr_tgt_wr = wr.tgt;

`ifdef BTB_STATS_EN
  // ------------------------------------------------------------------
  // Saturating lookup/hit counters. A flush clears them.
  // ------------------------------------------------------------------
  logic [31:0] stat_lookups_q, stat_hits_q;

  always_ff @(posedge clk) begin
    if (rst || flush_req) begin
      stat_lookups_q <= '0;
      stat_hits_q    <= '0;
    end else begin
      if (fetch_vld && btb_ready && (stat_lookups_q != 32'hFFFF_FFFF)) begin
        stat_lookups_q <= stat_lookups_q + 32'd1;
      end
      if (pred_taken && (stat_hits_q != 32'hFFFF_FFFF)) begin
        stat_hits_q <= stat_hits_q + 32'd1;
      end
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_hits    = stat_hits_q;
`endif

endmodule

// File: tb/tb_btb_ctrl.sv
// tb_btb_ctrl: randomized scoreboard bench for btb_ctrl.
// Latency: expectations are pushed when stimulus is driven and popped on the falling edge.
// Backpressure: not applicable; a behavioural array model stands in for the storage RAM.

module tb_btb_ctrl;
  localparam int IDX_W = 10;
  localparam int TAG_W = 20;
  localparam int N     = 1 << IDX_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              fetch_vld = 1'b0;
  logic [31:0]       fetch_pc = '0;
  logic              upd_vld = 1'b0;
  logic [31:0]       upd_pc = '0;
  logic [31:0]       upd_target = '0;
  logic              upd_taken = 1'b0;
  logic              upd_was_hit = 1'b0;
  logic              flush_req = 1'b0;
  logic              pred_taken;
  logic [31:0]       pred_pc;
  logic              btb_ready;
  logic [IDX_W-1:0]  arr_r_addr;
  logic [TAG_W-1:0]  arr_tag_rd;
  logic              arr_vld_rd;
  logic [29:0]       arr_tgt_rd;
  logic              arr_w_en;
  logic [IDX_W-1:0]  arr_w_addr;
  logic [TAG_W-1:0]  arr_tag_wr;
  logic              arr_vld_wr;
  logic [29:0]       arr_tgt_wr;
`ifdef BTB_STATS_EN
  logic [31:0]       stat_lookups;
  logic [31:0]       stat_hits;
`endif

  btb_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .fetch_vld(fetch_vld), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_pc(pred_pc),
    .upd_vld(upd_vld), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_was_hit(upd_was_hit),
    .flush_req(flush_req), .btb_ready(btb_ready),
    .arr_r_addr(arr_r_addr), .arr_tag_rd(arr_tag_rd),
    .arr_vld_rd(arr_vld_rd), .arr_tgt_rd(arr_tgt_rd),
    .arr_w_en(arr_w_en), .arr_w_addr(arr_w_addr), .arr_tag_wr(arr_tag_wr),
    .arr_vld_wr(arr_vld_wr), .arr_tgt_wr(arr_tgt_wr)
`ifdef BTB_STATS_EN
    , .stat_lookups(stat_lookups), .stat_hits(stat_hits)
`endif
  );

  // ---------------- PC pool (shared indices, differing tags) ----------------
  logic [31:0] pool [16];

  // ---------------- Storage array stand-in (no reset, preloaded with junk) --
  logic [TAG_W-1:0] mem_tag [N];
  logic             mem_vld [N];
  logic [29:0]      mem_tgt [N];
  bit               mem_init_done = 1'b0;

  assign arr_tag_rd = mem_tag[arr_r_addr];
  assign arr_vld_rd = mem_vld[arr_r_addr];
  assign arr_tgt_rd = mem_tgt[arr_r_addr];

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < N; i++) begin
        mem_vld[i] = 1'($urandom_range(0, 1));
        mem_tag[i] = TAG_W'($urandom);
        mem_tgt[i] = 30'($urandom);
      end
      // Stale valid entries that match the pool PCs. Only a correct sweep or
      // correct ready gating hides them.
      for (int i = 0; i < 16; i++) begin
        mem_vld[pool[i][IDX_W+1:2]] = 1'b1;
        mem_tag[pool[i][IDX_W+1:2]] = pool[i][31:IDX_W+2];
      end
      mem_init_done = 1'b1;
    end
    if (arr_w_en === 1'b1) begin
      mem_tag[arr_w_addr] = arr_tag_wr;
      mem_vld[arr_w_addr] = arr_vld_wr;
      mem_tgt[arr_w_addr] = arr_tgt_wr;
    end
  end

  // ---------------- Scoreboard ----------------
  typedef struct packed {
    logic [IDX_W-1:0] addr;
    logic [TAG_W-1:0] tag;
    logic             vld;
    logic [29:0]      tgt;
  } wr_exp_t;

  typedef struct packed {
    logic             ready;
    logic             taken;
    logic [31:0]      pc;
    logic [IDX_W-1:0] raddr;
    logic             wen;
    logic [31:0]      lk;
    logic [31:0]      hits;
  } cyc_exp_t;

  wr_exp_t  wr_q  [$];
  cyc_exp_t cyc_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- Reference model (what the BTB should hold) ----------------
  bit               m_run = 1'b0;
  int               m_pos = 0;
  bit               m_has_pend = 1'b0;
  wr_exp_t          m_pend;
  bit               c_vld [N];
  logic [TAG_W-1:0] c_tag [N];
  logic [29:0]      c_tgt [N];
  longint           m_lk = 0;
  longint           m_hits = 0;

  function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] pc);
    return IDX_W'((pc >> 2) % N);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
    return TAG_W'(pc >> (IDX_W + 2));
  endfunction

  task automatic model_step();
    cyc_exp_t ce;
    wr_exp_t  we;
    wr_exp_t  ue;
    bit       do_wr;
    bit       hit;
    bit       u_wr;
    logic [IDX_W-1:0] fi;
    do_wr = 1'b0;
    we    = '0;
    fi    = idx_of(fetch_pc);
    ce.raddr = fi;
    ce.ready = !rst && m_run;
    hit      = ce.ready && fetch_vld && c_vld[fi] && (c_tag[fi] == tag_of(fetch_pc));
    ce.taken = hit;
    ce.pc    = hit ? {c_tgt[fi], 2'b00} : 32'd0;
    ce.lk    = 32'(m_lk);
    ce.hits  = 32'(m_hits);

    u_wr   = upd_vld && (upd_taken || upd_was_hit);
    ue     = '0;
    ue.addr = idx_of(upd_pc);
    if (upd_taken) begin
      ue.tag = tag_of(upd_pc);
      ue.vld = 1'b1;
      ue.tgt = upd_target[31:2];
    end

    if (rst) begin
      m_run = 1'b0; m_pos = 0; m_has_pend = 1'b0; m_lk = 0; m_hits = 0;
    end else begin
      if (flush_req) begin
        m_lk = 0; m_hits = 0;
      end else begin
        if (fetch_vld && ce.ready && m_lk < 64'hFFFF_FFFF) m_lk++;
        if (hit && m_hits < 64'hFFFF_FFFF) m_hits++;
      end
      if (!m_run) begin
        we.addr = IDX_W'(m_pos);
        do_wr   = 1'b1;
        if (flush_req) begin
          m_pos = 0; m_has_pend = 1'b0;
        end else begin
          if (u_wr) begin m_has_pend = 1'b1; m_pend = ue; end
          m_pos++;
          if (m_pos == N) begin m_run = 1'b1; m_pos = 0; end
        end
      end else if (flush_req) begin
        m_run = 1'b0; m_pos = 0; m_has_pend = 1'b0;
      end else if (m_has_pend) begin
        we = m_pend; do_wr = 1'b1;
        m_has_pend = u_wr;
        if (u_wr) m_pend = ue;
      end else if (u_wr) begin
        we = ue; do_wr = 1'b1;
      end
    end

    ce.wen = do_wr;
    if (do_wr) begin
      wr_q.push_back(we);
      c_vld[we.addr] = we.vld;
      c_tag[we.addr] = we.tag;
      c_tgt[we.addr] = we.tgt;
    end
    cyc_q.push_back(ce);
  endtask

  // ---------------- Monitor ----------------
  always @(negedge clk) begin
    cyc_exp_t ce;
    wr_exp_t  we;
    if (cyc_q.size() > 0) begin
      ce = cyc_q.pop_front();
      n_cmp++;
      if ({btb_ready, pred_taken, pred_pc, arr_r_addr, arr_w_en} !==
          {ce.ready, ce.taken, ce.pc, ce.raddr, ce.wen}) begin
        n_bad++;
        $display("FAIL lookup t=%0t got ready=%b taken=%b pc=%h raddr=%h wen=%b want ready=%b taken=%b pc=%h raddr=%h wen=%b",
                 $time, btb_ready, pred_taken, pred_pc, arr_r_addr, arr_w_en,
                 ce.ready, ce.taken, ce.pc, ce.raddr, ce.wen);
      end
`ifdef BTB_STATS_EN
      n_cmp++;
      if ({stat_lookups, stat_hits} !== {ce.lk, ce.hits}) begin
        n_bad++;
        $display("FAIL stats t=%0t got lk=%0d hits=%0d want lk=%0d hits=%0d",
                 $time, stat_lookups, stat_hits, ce.lk, ce.hits);
      end
`endif
    end
    if (arr_w_en === 1'b1) begin
      n_cmp++;
      if (wr_q.size() == 0) begin
        n_bad++;
        $display("FAIL write_unexpected t=%0t got addr=%h vld=%b want no write",
                 $time, arr_w_addr, arr_vld_wr);
      end else begin
        we = wr_q.pop_front();
        if ({arr_w_addr, arr_tag_wr, arr_vld_wr, arr_tgt_wr} !== we) begin
          n_bad++;
          $display("FAIL write t=%0t got addr=%h tag=%h vld=%b tgt=%h want addr=%h tag=%h vld=%b tgt=%h",
                   $time, arr_w_addr, arr_tag_wr, arr_vld_wr, arr_tgt_wr,
                   we.addr, we.tag, we.vld, we.tgt);
        end
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic step(input bit r, input bit fv, input logic [31:0] fpc,
                      input bit uv, input logic [31:0] upc, input logic [31:0] utg,
                      input bit ut, input bit uh, input bit fl);
    @(posedge clk);
    #1;
    rst = r; fetch_vld = fv; fetch_pc = fpc;
    upd_vld = uv; upd_pc = upc; upd_target = utg;
    upd_taken = ut; upd_was_hit = uh; flush_req = fl;
    model_step();
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    if ($urandom_range(0, 9) == 0) p = $urandom;
    else p = pool[$urandom_range(0, 15)];
    return p;
  endfunction

  // Random cycle: upd_pct = update chance in percent; fl_pm / rst_pm = per-mille chance.
  task automatic rnd(input int upd_pct, input int fl_pm, input int rst_pm);
    step(($urandom_range(0, 999) < rst_pm), 1'($urandom_range(0, 1)), rand_pc(),
         ($urandom_range(0, 99) < upd_pct), rand_pc(), $urandom,
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         ($urandom_range(0, 999) < fl_pm));
  endtask

  task automatic look(input logic [31:0] pc);
    step(1'b0, 1'b1, pc, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    pool[0] = 32'h0000_1040; pool[1] = 32'h0000_2040;
    pool[2] = 32'h0000_0100; pool[3] = 32'h0000_0000;
    for (int i = 4; i < 16; i++) begin
      pool[i] = {12'($urandom), 10'($urandom_range(0, 3) * 255), 2'b00} ^ 32'($urandom_range(0, 7) << 2);
    end

    // Reset with busy inputs: no writes, ready low, no prediction.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, pool[i], 1'b1, pool[i], $urandom, 1'b1, 1'b1, 1'b0);
    end

    // Power-on sweep. Two late updates to 0x100: only the second one must land.
    for (int i = 0; i < N; i++) begin
      if (i == N - 4)      step(1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 32'h500, 1'b1, 1'b0, 1'b0);
      else if (i == N - 2) step(1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 32'h600, 1'b1, 1'b0, 1'b0);
      else if (i < N - 8)  rnd(30, 0, 0);
      else                 look(rand_pc());
    end
    // First RUN cycle: the pending write lands now, and a new update is parked behind it.
    step(1'b0, 1'b1, 32'h100, 1'b1, 32'h2040, 32'h3000, 1'b1, 1'b0, 1'b0);
    look(32'h100);
    look(32'h2040);

    // Insert, hit, same-index miss, evict, non-writing not-taken.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1040, 32'h2000, 1'b1, 1'b0, 1'b0);
    look(32'h1040);
    look(32'h2040);
    step(1'b0, 1'b1, 32'h1040, 1'b1, 32'h1040, 32'h0, 1'b0, 1'b1, 1'b0);
    look(32'h1040);
    step(1'b0, 1'b1, 32'h1040, 1'b1, 32'h1040, 32'h0, 1'b0, 1'b0, 1'b0);
    look(32'h1040);

    // Flush alongside an update, re-flush at sweep index 500, then lookups must miss.
    step(1'b0, 1'b1, 32'h100, 1'b1, 32'h1040, 32'h7000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 500; i++) look(rand_pc());
    step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N + 8; i++) look(rand_pc());

    // Random traffic with rare flushes and resets.
    for (int i = 0; i < 4000; i++) rnd(40, 1, 1);

    // Reset in the middle of a sweep, with updates in flight.
    step(1'b0, 1'b1, rand_pc(), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) rnd(50, 0, 0);
    step(1'b1, 1'b1, pool[0], 1'b1, pool[0], $urandom, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, pool[1], 1'b1, pool[1], $urandom, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N + 200; i++) rnd(40, 0, 0);

    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (wr_q.size() != 0) begin
      n_bad++;
      $display("FAIL writes_missing got %0d expected writes never seen want 0", wr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
